// File: rtl/winocnn_pkg.sv
// Shared types and constants for the WinoCNN job sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package winocnn_pkg;

    localparam int WORD_W_DEF = 512;
    localparam int ADDR_W_DEF = 8;

    localparam logic [1:0] SCAN_OFF  = 2'b00;
    localparam logic [1:0] SCAN_RUN  = 2'b01;
    localparam logic [1:0] SCAN_READ = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRN_ADDR,
        ST_DRN_CAP,
        ST_DRN_HOLD,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/run_watchdog.sv
// Saturating run-phase watchdog; expire is high while the count sits at all-ones.
// Latency: expire rises 2**TMO_W-1 enabled cycles after clear drops.
// Backpressure: none; holds its count while enable is low.
module run_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMO_W-1:0] cnt_q;

    assign expire = &cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expire) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

endmodule

// File: rtl/winocnn_run_sequencer.sv
// Sequences one WinoCNN job: load input SRAMs, run the core, drain both output SRAMs.
// Latency: load 1 beat/cycle + 1 flush cycle; drain >= 3 cycles per word; all outputs registered.
// Backpressure: in_valid/in_ready on load, out_valid/out_ready on drain (out_* held while stalled).
module winocnn_run_sequencer
    import winocnn_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 128,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        cfg_id,
    input  logic [7:0]        cfg_od,
    input  logic [8:0]        cfg_width,
    input  logic [8:0]        cfg_height,
    input  logic              cfg_size_type,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [WORD_W-1:0] in_weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [WORD_W-1:0] out_mem1,
    output logic [WORD_W-1:0] out_mem2,
    output logic              core_reset,
    output logic [3:0]        total_id,
    output logic [7:0]        total_od,
    output logic [8:0]        total_width,
    output logic [8:0]        total_height,
    output logic              total_size_type,
    output logic              wen,
    output logic              input_mem_scan_mode,
    output logic [1:0]        output_mem_scan_mode,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [WORD_W-1:0] data_mem_scan_in,
    output logic [WORD_W-1:0] weight_mem_scan_in,
    input  logic              conv_completed,
    input  logic [WORD_W-1:0] output_mem1_scan_out,
    input  logic [WORD_W-1:0] output_mem2_scan_out,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              expire;

    logic              core_reset_d, in_ready_d, in_mode_d, wen_d;
    logic              out_valid_d, busy_d, done_d, timeout_d;
    logic [1:0]        out_mode_d;
    logic [ADDR_W-1:0] scan_addr_d, out_addr_d;
    logic [WORD_W-1:0] data_d, weight_d, mem1_d, mem2_d;
    logic [3:0]        id_d;
    logic [7:0]        od_d;
    logic [8:0]        width_d, height_d;
    logic              size_type_d;

    run_watchdog #(.TMO_W(TMO_W)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != ST_RUN),
        .enable (state_q == ST_RUN),
        .expire (expire)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        core_reset_d = core_reset;
        in_ready_d   = in_ready;
        in_mode_d    = input_mem_scan_mode;
        out_mode_d   = output_mem_scan_mode;
        wen_d        = wen;
        scan_addr_d  = scan_addr;
        data_d       = data_mem_scan_in;
        weight_d     = weight_mem_scan_in;
        out_valid_d  = out_valid;
        out_addr_d   = out_addr;
        mem1_d       = out_mem1;
        mem2_d       = out_mem2;
        id_d         = total_id;
        od_d         = total_od;
        width_d      = total_width;
        height_d     = total_height;
        size_type_d  = total_size_type;
        done_d       = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    id_d        = cfg_id;
                    od_d        = cfg_od;
                    width_d     = cfg_width;
                    height_d    = cfg_height;
                    size_type_d = cfg_size_type;
                    addr_d      = '0;
                    in_ready_d  = 1'b1;
                    in_mode_d   = 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // in_ready low inside LOAD marks the flush cycle that lets the last word land
                if (in_ready) begin
                    if (in_valid) begin
                        data_d      = in_data;
                        weight_d    = in_weight;
                        scan_addr_d = addr_q;
                        if (addr_q == LAST_ADDR) begin
                            in_ready_d = 1'b0;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end else begin
                    in_mode_d    = 1'b0;
                    core_reset_d = 1'b0;
                    wen_d        = 1'b1;
                    out_mode_d   = SCAN_RUN;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (conv_completed) begin
                    addr_d      = '0;
                    scan_addr_d = '0;
                    wen_d       = 1'b0;
                    out_mode_d  = SCAN_READ;
                    state_d     = ST_DRN_ADDR;
                end else if (expire) begin
                    timeout_d    = 1'b1;
                    core_reset_d = 1'b1;
                    wen_d        = 1'b0;
                    out_mode_d   = SCAN_OFF;
                    state_d      = ST_IDLE;
                end
            end
            ST_DRN_ADDR: begin
                state_d = ST_DRN_CAP;
            end
            ST_DRN_CAP: begin
                mem1_d      = output_mem1_scan_out;
                mem2_d      = output_mem2_scan_out;
                out_addr_d  = addr_q;
                out_valid_d = 1'b1;
                state_d     = ST_DRN_HOLD;
            end
            ST_DRN_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        done_d       = 1'b1;
                        core_reset_d = 1'b1;
                        out_mode_d   = SCAN_OFF;
                        state_d      = ST_DONE;
                    end else begin
                        // next read address goes out as DRN_ADDR begins
                        addr_d      = addr_q + ADDR_W'(1);
                        scan_addr_d = addr_q + ADDR_W'(1);
                        state_d     = ST_DRN_ADDR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                core_reset_d = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d      = ST_IDLE;
            core_reset_d = 1'b1;
            in_ready_d   = 1'b0;
            in_mode_d    = 1'b0;
            out_mode_d   = SCAN_OFF;
            wen_d        = 1'b0;
            out_valid_d  = 1'b0;
            done_d       = 1'b0;
            timeout_d    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= ST_IDLE;
            addr_q               <= '0;
            core_reset           <= 1'b1;
            in_ready             <= 1'b0;
            input_mem_scan_mode  <= 1'b0;
            output_mem_scan_mode <= SCAN_OFF;
            wen                  <= 1'b0;
            scan_addr            <= '0;
            data_mem_scan_in     <= '0;
            weight_mem_scan_in   <= '0;
            out_valid            <= 1'b0;
            out_addr             <= '0;
            out_mem1             <= '0;
            out_mem2             <= '0;
            total_id             <= '0;
            total_od             <= '0;
            total_width          <= '0;
            total_height         <= '0;
            total_size_type      <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            timeout              <= 1'b0;
        end else begin
            state_q              <= state_d;
            addr_q               <= addr_d;
            core_reset           <= core_reset_d;
            in_ready             <= in_ready_d;
            input_mem_scan_mode  <= in_mode_d;
            output_mem_scan_mode <= out_mode_d;
            wen                  <= wen_d;
            scan_addr            <= scan_addr_d;
            data_mem_scan_in     <= data_d;
            weight_mem_scan_in   <= weight_d;
            out_valid            <= out_valid_d;
            out_addr             <= out_addr_d;
            out_mem1             <= mem1_d;
            out_mem2             <= mem2_d;
            total_id             <= id_d;
            total_od             <= od_d;
            total_width          <= width_d;
            total_height         <= height_d;
            total_size_type      <= size_type_d;
            busy                 <= busy_d;
            done                 <= done_d;
            timeout              <= timeout_d;
        end
    end

endmodule

// File: tb/tb_winocnn_run_sequencer.sv
// Directed-plus-random bench for winocnn_run_sequencer with a behavioural SRAM model.
// Latency: n/a. Backpressure: out_ready toggled randomly during drain.
module tb_winocnn_run_sequencer;

    localparam int WORD_W = 512;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 128;
    localparam int TMO_W  = 8;
    localparam int RUN_N  = 200;
    localparam int SNAP_W = ADDR_W + 2 * WORD_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0, abort = 1'b0;
    logic [3:0]        cfg_id = '0;
    logic [7:0]        cfg_od = '0;
    logic [8:0]        cfg_width = '0, cfg_height = '0;
    logic              cfg_size_type = 1'b0;
    logic              in_valid = 1'b0, in_ready;
    logic [WORD_W-1:0] in_data = '0, in_weight = '0;
    logic              out_valid, out_ready = 1'b0;
    logic [ADDR_W-1:0] out_addr, scan_addr;
    logic [WORD_W-1:0] out_mem1, out_mem2, data_mem_scan_in, weight_mem_scan_in;
    logic              core_reset, total_size_type, wen, input_mem_scan_mode;
    logic [3:0]        total_id;
    logic [7:0]        total_od;
    logic [8:0]        total_width, total_height;
    logic [1:0]        output_mem_scan_mode;
    logic              conv_completed = 1'b0;
    logic [WORD_W-1:0] om1 = '0, om2 = '0;
    logic              busy, done, timeout;

    logic [WORD_W-1:0] mem1 [256];
    logic [WORD_W-1:0] mem2 [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Output SRAMs of the core: registered read, data one clock after scan_addr.
    always @(posedge clk) begin
        om1 <= mem1[scan_addr];
        om2 <= mem2[scan_addr];
    end

    winocnn_run_sequencer #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_id(cfg_id), .cfg_od(cfg_od), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_size_type(cfg_size_type),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_mem1(out_mem1), .out_mem2(out_mem2),
        .core_reset(core_reset),
        .total_id(total_id), .total_od(total_od), .total_width(total_width),
        .total_height(total_height), .total_size_type(total_size_type),
        .wen(wen), .input_mem_scan_mode(input_mem_scan_mode),
        .output_mem_scan_mode(output_mem_scan_mode), .scan_addr(scan_addr),
        .data_mem_scan_in(data_mem_scan_in), .weight_mem_scan_in(weight_mem_scan_in),
        .conv_completed(conv_completed),
        .output_mem1_scan_out(om1), .output_mem2_scan_out(om2),
        .busy(busy), .done(done), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_W-1:0] rnd_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic do_start(input logic [3:0] id, input logic [7:0] od,
                            input logic [8:0] w, input logic [8:0] h, input logic st);
        cfg_id = id; cfg_od = od; cfg_width = w; cfg_height = h; cfg_size_type = st;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_id = 4'($urandom); cfg_od = 8'($urandom);
        cfg_width = 9'($urandom); cfg_height = 9'($urandom); cfg_size_type = ~st;
    endtask

    // Streams nbeats random word pairs; a write is any change of the scan registers.
    task automatic do_load(input int nbeats, input int gap, output int writes, output int bad);
        logic [SNAP_W-1:0] prev, cur;
        logic [WORD_W-1:0] d, w;
        logic beat;
        int b;
        writes = 0; bad = 0; b = 0;
        prev = {scan_addr, data_mem_scan_in, weight_mem_scan_in};
        for (int c = 0; c < 4 * nbeats + 8 && b < nbeats; c++) begin
            in_valid  = (gap == 0) || (c % gap != gap - 1);
            d = rnd_word(); w = rnd_word();
            in_data   = d;
            in_weight = w;
            beat = in_valid && in_ready;
            tick();
            cur = {scan_addr, data_mem_scan_in, weight_mem_scan_in};
            if (cur != prev) writes++;
            if (beat) begin
                if (cur !== {ADDR_W'(b), d, w}) bad++;
                b++;
            end else if (cur !== prev) begin
                bad++;
            end
            prev = cur;
        end
        in_valid = 1'b0;
    endtask

    int wr, bad, wen_cnt, run_bad, got, dones, stall_bad, word_bad, gap_bad, prev_hs, extra;
    logic prev_stall;
    logic [SNAP_W-1:0] snap, saved;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = rnd_word();
            mem2[i] = rnd_word();
        end
        repeat (3) tick();

        // Reset values
        chk("rst_core_reset", core_reset, 1);
        chk("rst_ctl_zero", {busy, in_ready, out_valid, wen, input_mem_scan_mode,
                             output_mem_scan_mode, done, timeout}, 0);
        chk("rst_data_zero", data_mem_scan_in | weight_mem_scan_in | out_mem1 | out_mem2, 0);
        chk("rst_addr_cfg_zero", {scan_addr, out_addr, total_id, total_od, total_width,
                                  total_height, total_size_type}, 0);
        reset = 1'b0;
        tick();

        // 1: async reset in the middle of a load
        do_start(4'd3, 8'd7, 9'd10, 9'd12, 1'b0);
        do_load(40, 0, wr, bad);
        chk("t1_partial_writes", wr, 40);
        chk("t1_partial_scan_addr", scan_addr, 39);
        #2 reset = 1'b1;
        #1;
        chk("t1_rst_core_reset", core_reset, 1);
        chk("t1_rst_modes", {input_mem_scan_mode, output_mem_scan_mode, wen, in_ready, busy}, 0);
        chk("t1_rst_scan", {scan_addr, data_mem_scan_in[31:0]}, 0);
        tick();
        reset = 1'b0;
        tick();

        // 2: full load with in_valid gaps
        do_start(4'd1, 8'd1, 9'd24, 9'd24, 1'b1);
        chk("t2_load_entry", {in_ready, input_mem_scan_mode, core_reset, busy}, 4'b1111);
        chk("t2_cfg_latched", {total_id, total_od, total_width, total_height, total_size_type},
            {4'd1, 8'd1, 9'd24, 9'd24, 1'b1});
        do_load(DEPTH, 3, wr, bad);
        chk("t2_write_count", wr, DEPTH);
        chk("t2_write_content", bad, 0);
        chk("t2_ready_after_last", in_ready, 0);
        chk("t2_mode_holds_last", input_mem_scan_mode, 1);
        saved = {scan_addr, data_mem_scan_in, weight_mem_scan_in};
        in_valid = 1'b1; in_data = rnd_word(); in_weight = rnd_word();
        tick();
        in_valid = 1'b0;
        chk("t2_no_extra_write", {scan_addr, data_mem_scan_in, weight_mem_scan_in}, saved);
        chk("t2_mode_fell", input_mem_scan_mode, 0);

        // 3: run phase, conv_completed after RUN_N cycles
        wen_cnt = 0; run_bad = 0;
        for (int c = 0; c < 1000; c++) begin
            if (!wen) break;
            wen_cnt++;
            if (core_reset !== 1'b0 || output_mem_scan_mode !== 2'b01) run_bad++;
            conv_completed = (wen_cnt == RUN_N + 1);
            tick();
        end
        conv_completed = 1'b0;
        chk("t3_run_span", wen_cnt, RUN_N + 1);
        chk("t3_run_ctl", run_bad, 0);
        chk("t3_read_entry", {output_mem_scan_mode, wen, core_reset}, {2'b11, 1'b0, 1'b0});

        // 4: drain with random backpressure
        got = 0; dones = 0; stall_bad = 0; word_bad = 0; gap_bad = 0; prev_hs = 0;
        prev_stall = 1'b0; snap = '0;
        for (int c = 0; c < 5000 && got < DEPTH; c++) begin
            if (done) dones++;
            if (prev_stall && (!out_valid || {out_addr, out_mem1, out_mem2} !== snap)) stall_bad++;
            out_ready = 1'($urandom);
            if (out_valid && out_ready) begin
                if (out_addr !== ADDR_W'(got) || out_mem1 !== mem1[got] || out_mem2 !== mem2[got])
                    word_bad++;
                if (got > 0 && c - prev_hs < 3) gap_bad++;
                prev_hs = c;
                got++;
            end
            prev_stall = out_valid && !out_ready;
            snap = {out_addr, out_mem1, out_mem2};
            tick();
        end
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done) dones++;
            tick();
        end
        chk("t4_words_out", got, DEPTH);
        chk("t4_word_content", word_bad, 0);
        chk("t4_stall_stable", stall_bad, 0);
        chk("t4_min_word_cycles", gap_bad, 0);
        chk("t4_done_pulses", dones, 1);
        chk("t4_idle_after", {busy, core_reset, output_mem_scan_mode}, {1'b0, 1'b1, 2'b00});

        // 5: watchdog timeout
        do_start(4'($urandom), 8'($urandom), 9'($urandom), 9'($urandom), 1'b0);
        do_load(DEPTH, 0, wr, bad);
        chk("t5_write_count", wr, DEPTH);
        wen_cnt = 0; dones = 0; extra = 0;
        for (int c = 0; c < 2000; c++) begin
            if (timeout) begin
                extra = 1;
                break;
            end
            if (done) dones++;
            if (wen) wen_cnt++;
            tick();
        end
        chk("t5_timeout_seen", extra, 1);
        chk("t5_run_cycles", wen_cnt, 2 ** TMO_W);
        chk("t5_idle_state", {busy, wen, core_reset, output_mem_scan_mode}, {1'b0, 1'b0, 1'b1, 2'b00});
        tick();
        chk("t5_timeout_pulse", timeout, 0);
        chk("t5_no_done", dones + 32'(done), 0);

        // 6: abort while stalled in drain, with start in the same cycle
        do_start(4'd2, 8'd2, 9'd8, 9'd8, 1'b1);
        do_load(DEPTH, 0, wr, bad);
        for (int c = 0; c < 10 && !wen; c++) tick();
        conv_completed = 1'b1;
        tick();
        conv_completed = 1'b0;
        chk("t6_first_cycle_conv", {output_mem_scan_mode, wen}, {2'b11, 1'b0});
        for (int c = 0; c < 10 && !out_valid; c++) tick();
        chk("t6_first_word", {out_valid, out_addr, out_mem1[31:0]}, {1'b1, ADDR_W'(0), mem1[0][31:0]});
        tick();
        tick();
        chk("t6_stalled_hold", {out_valid, out_addr}, {1'b1, ADDR_W'(0)});
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("t6_abort_idle", {out_valid, busy, core_reset, wen, in_ready, input_mem_scan_mode,
                              output_mem_scan_mode}, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            if (done || timeout || busy) extra++;
            tick();
        end
        chk("t6_quiet_after_abort", extra, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish within 1 ms");
        $fatal(1, "bench time limit");
    end

endmodule
